// File: rtl/max_search_requester_pkg.sv
// max_search_requester_pkg: shared widths, FSM state encoding and the array packing rule
package max_search_requester_pkg;
  localparam int DATA_W = 8;
  localparam int N_ELEM = 8;
  localparam int ARRAY_W = DATA_W * N_ELEM;
  typedef enum logic [1:0] {FILL, LAUNCH, WAIT, RESULT} state_e;
  function automatic int elem_lsb(input int i);
    return ARRAY_W - DATA_W * (i + 1);
  endfunction
endpackage

// File: rtl/max_search_requester_if.sv
// max_search_requester_if: byte stream in, engine launch/completion, result stream out
// master = requester side, slave = byte source / engine / result sink side
interface max_search_requester_if;
  import max_search_requester_pkg::*;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic               in_ready;
  logic [ARRAY_W-1:0] array_o;
  logic               start_o;
  logic               completed_i;
  logic [3:0]         max_index_i;
  logic               res_valid;
  logic               res_ready;
  logic [3:0]         res_index;
  logic [DATA_W-1:0]  res_value;
  logic               res_error;
  modport master (
    input  in_valid, in_data, completed_i, max_index_i, res_ready,
    output in_ready, array_o, start_o, res_valid, res_index, res_value, res_error
  );
  modport slave (
    output in_valid, in_data, completed_i, max_index_i, res_ready,
    input  in_ready, array_o, start_o, res_valid, res_index, res_value, res_error
  );
endinterface

// File: rtl/max_search_packer.sv
// max_search_packer: 8x8 slot file, write port, combinational read by index, flattened 64-bit view
// ports: clk/reset; we/addr/wr_data write; rd_idx -> rd_data read; array_o packed slots
module max_search_packer
  import max_search_requester_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [2:0]         addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [2:0]         rd_idx,
  output logic [DATA_W-1:0]  rd_data,
  output logic [ARRAY_W-1:0] array_o
);
  logic [DATA_W-1:0] slot_q [N_ELEM];
  logic [DATA_W-1:0] slot_d [N_ELEM];
  always_comb begin
    slot_d = slot_q;
    if (we) slot_d[addr] = wr_data;
  end
  always_ff @(posedge clk) begin
    if (reset) slot_q <= '{default: '0};
    else slot_q <= slot_d;
  end
  assign rd_data = slot_q[rd_idx];
  for (genvar i = 0; i < N_ELEM; i++) begin : g_pack
    assign array_o[elem_lsb(i) +: DATA_W] = slot_q[i];
  end
endmodule

// File: rtl/max_search_requester.sv
// max_search_requester: gathers 8 signed bytes, launches the max-search engine, returns index and winning value
// ports: clk, reset (sync, active-high); bus carries byte input, engine start/completion and result output
module max_search_requester
  import max_search_requester_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                  clk,
  input logic                  reset,
  max_search_requester_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_e            state_q, state_d;
  logic [2:0]        count_q, count_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              start_q, start_d;
  logic              res_valid_q, res_valid_d;
  logic              res_error_q, res_error_d;
  logic [3:0]        res_index_q, res_index_d;
  logic [DATA_W-1:0] res_value_q, res_value_d;
  logic [DATA_W-1:0] rd_data;
  logic              we;
  assign bus.in_ready = state_q == FILL && !reset;
  assign we = bus.in_valid && bus.in_ready;
  max_search_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .addr    (count_q),
    .wr_data (bus.in_data),
    .rd_idx  (bus.max_index_i[2:0]),
    .rd_data (rd_data),
    .array_o (bus.array_o)
  );
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    res_index_d = res_index_q;
    res_value_d = res_value_q;
    res_error_d = res_error_q;
    case (state_q)
      FILL: if (we) begin
        count_d = count_q + 3'd1;
        state_d = count_q == 3'(N_ELEM - 1) ? LAUNCH : FILL;
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (bus.completed_i) begin
          res_index_d = bus.max_index_i;
          res_error_d = bus.max_index_i >= 4'(N_ELEM);
          res_value_d = res_error_d ? '0 : rd_data;
          state_d = RESULT;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          res_index_d = '0;
          res_value_d = '0;
          res_error_d = 1'b1;
          state_d = RESULT;
        end
      end
      default: if (bus.res_ready) begin
        count_d = '0;
        state_d = FILL;
      end
    endcase
    start_d = state_d == LAUNCH;
    res_valid_d = state_d == RESULT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      count_q <= '0;
      timer_q <= '0;
      start_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_index_q <= '0;
      res_value_q <= '0;
      res_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      start_q <= start_d;
      res_valid_q <= res_valid_d;
      res_index_q <= res_index_d;
      res_value_q <= res_value_d;
      res_error_q <= res_error_d;
    end
  end
  assign bus.start_o = start_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_index = res_index_q;
  assign bus.res_value = res_value_q;
  assign bus.res_error = res_error_q;
endmodule

// File: tb/tb_max_search_requester.sv
// tb_max_search_requester: randomized runs against a transaction-level reference model
module tb_max_search_requester;
  localparam int TIMEOUT = 64;
  localparam int COLLECT = 0, LAUNCHED = 1, WAITING = 2, HOLDING = 3;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  max_search_requester_if itf ();
  max_search_requester #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (itf.master)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // Reference: what has been accepted, what the run has reported, and how long it has waited.
  logic [7:0] m_arr [8];
  int  ph = COLLECT, got = 0, waited = 0;
  bit  ok = 0;
  logic [3:0] m_idx;
  logic [7:0] m_val;
  logic m_err;
  initial forever begin
    @(negedge clk);
    if (ok) begin
      chk("in_ready", itf.in_ready, ph == COLLECT && !reset);
      chk("array_o", itf.array_o, {m_arr[0], m_arr[1], m_arr[2], m_arr[3], m_arr[4], m_arr[5], m_arr[6], m_arr[7]});
      chk("start_o", itf.start_o, ph == LAUNCHED);
      chk("res_valid", itf.res_valid, ph == HOLDING);
      chk("res_index", itf.res_index, m_idx);
      chk("res_value", itf.res_value, m_val);
      chk("res_error", itf.res_error, m_err);
    end
    if (reset) begin
      ph = COLLECT; got = 0; waited = 0; ok = 1;
      foreach (m_arr[i]) m_arr[i] = 8'h00;
      m_idx = 0; m_val = 0; m_err = 0;
    end else if (ph == COLLECT) begin
      if (itf.in_valid) begin
        m_arr[got] = itf.in_data;
        got++;
        if (got == 8) begin got = 0; ph = LAUNCHED; end
      end
    end else if (ph == LAUNCHED) begin
      ph = WAITING; waited = 0;
    end else if (ph == WAITING) begin
      waited++;
      if (itf.completed_i) begin
        m_idx = itf.max_index_i;
        m_err = m_idx >= 8;
        m_val = m_err ? 8'h00 : m_arr[int'(m_idx)];
        ph = HOLDING;
      end else if (waited == TIMEOUT) begin
        m_idx = 0; m_val = 0; m_err = 1; ph = HOLDING;
      end
    end else if (itf.res_ready) begin
      ph = COLLECT;
    end
  end
  // Engine behaviour: index of the first largest signed element.
  function automatic logic [3:0] first_max(input logic [63:0] a);
    int best = 0;
    for (int i = 1; i < 8; i++)
      if ($signed(a[63-8*i -: 8]) > $signed(a[63-8*best -: 8])) best = i;
    return 4'(best);
  endfunction
  // resp: WAIT cycle (1-based) on which completed_i is raised, 0 = never.
  // ovr: forced engine index, -1 = first max. abort: WAIT cycle on which reset is applied, 0 = none.
  task automatic run(input logic [63:0] b, input bit gaps, input int resp, input int ovr, input int hold,
                     input bit stray, input bit bp9, input int abort, input bit lit,
                     input logic [3:0] e_idx, input logic [7:0] e_val, input bit e_err);
    int n = 0, t = 0;
    bit acc, seen = 0;
    logic [3:0] idx;
    idx = ovr >= 0 ? 4'(ovr) : first_max(b);
    while (n < 8 && t < 200) begin
      itf.in_valid = gaps ? t[0] : 1'b1;
      itf.in_data = b[63-8*n -: 8];
      itf.completed_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      itf.max_index_i = 4'($urandom);
      @(negedge clk);
      acc = itf.in_valid && itf.in_ready;
      step();
      if (acc) n++;
      t++;
    end
    itf.in_valid = 1'b0;
    itf.completed_i = 1'b0;
    chk("fill_count", 64'(n), 64'd8);
    for (t = 0; t < 10; t++) begin
      @(negedge clk);
      if (itf.start_o) begin seen = 1; break; end
      step();
    end
    chk("start_seen", 64'(seen), 64'd1);
    if (!seen) return;
    chk("start_lat", 64'(t), 64'd0);
    chk("array_launch", itf.array_o, b);
    step();
    if (abort > 0) begin
      repeat (abort - 1) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("abort_res_valid", 64'(itf.res_valid), 64'd0);
      chk("abort_start", 64'(itf.start_o), 64'd0);
      chk("abort_array", itf.array_o, 64'd0);
      chk("abort_in_ready", 64'(itf.in_ready), 64'd1);
      step();
      return;
    end
    if (resp > 0) begin
      repeat (resp - 1) step();
      itf.completed_i = 1'b1;
      itf.max_index_i = idx;
      step();
      itf.completed_i = 1'b0;
    end
    seen = 0;
    for (t = resp > 0 ? resp : 0; t < 100; t++) begin
      @(negedge clk);
      if (itf.res_valid) begin seen = 1; break; end
      step();
    end
    chk("res_seen", 64'(seen), 64'd1);
    if (resp == 0) chk("timeout_lat", 64'(t), 64'd64);
    if (lit) begin
      chk("lit_index", itf.res_index, e_idx);
      chk("lit_value", itf.res_value, e_val);
      chk("lit_error", 64'(itf.res_error), 64'(e_err));
    end
    step();
    repeat (hold) begin
      itf.in_valid = bp9;
      itf.in_data = 8'hAA;
      itf.completed_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      itf.max_index_i = 4'($urandom);
      step();
    end
    itf.res_ready = 1'b1;
    itf.in_valid = bp9;
    itf.in_data = 8'hAA;
    step();
    itf.res_ready = 1'b0;
    itf.in_valid = 1'b0;
    itf.completed_i = 1'b0;
    @(negedge clk);
    chk("resume_ready", 64'(itf.in_ready), 64'd1);
    step();
  endtask
  initial begin
    logic [63:0] rb;
    reset = 1'b1;
    itf.in_valid = 0; itf.in_data = 0; itf.completed_i = 0; itf.max_index_i = 0; itf.res_ready = 0;
    step();
    @(negedge clk);
    chk("rst_in_ready", 64'(itf.in_ready), 64'd0);
    chk("rst_array", itf.array_o, 64'd0);
    chk("rst_res_valid", 64'(itf.res_valid), 64'd0);
    step();
    reset = 1'b0;
    run(64'h05FD0C077F008004, 0, 3, -1, 1, 0, 0, 0, 1, 4'd4, 8'h7F, 0);
    rb = {$urandom, $urandom};
    run(rb, 1, 5, -1, 9, 0, 1, 0, 0, 0, 0, 0);
    rb = {$urandom, $urandom};
    run(rb, 0, 0, -1, 2, 0, 0, 0, 1, 4'd0, 8'h00, 1);
    run(64'h0102030405060708, 0, 64, -1, 1, 0, 0, 0, 1, 4'd7, 8'h08, 0);
    rb = {$urandom, $urandom};
    run(rb, 0, 2, 8, 1, 0, 0, 0, 1, 4'd8, 8'h00, 1);
    rb = {$urandom, $urandom};
    run(rb, 0, 2, -1, 4, 1, 0, 0, 0, 0, 0, 0);
    run(64'h1122334455667700, 0, 4, -1, 2, 1, 0, 0, 1, 4'd6, 8'h77, 0);
    rb = {$urandom, $urandom};
    run(rb, 0, 0, -1, 0, 0, 0, 3, 0, 0, 0, 0);
    run(64'hFFFFFFFFFFFFFFFF, 0, 2, -1, 1, 0, 0, 0, 1, 4'd0, 8'hFF, 0);
    for (int r = 0; r < 10; r++) begin
      rb = {$urandom, $urandom};
      run(rb, 1'($urandom_range(0, 1)), int'($urandom_range(1, 12)),
          $urandom_range(0, 3) == 0 ? int'($urandom_range(8, 15)) : -1,
          int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
